// File: rtl/sdram_wb_bridge.sv
// Wishbone-style bus to SDRAM controller request/ack bridge. It runs one transaction at a time,
// sequences the controller reset, and aborts with a sticky error flag if the controller never acks.
module sdram_wb_bridge #(
  parameter int RST_DLY   = 3,
  parameter int RDATA_DLY = 0,
  parameter int TIMEOUT   = 1023,
  parameter int TW        = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sys_reset,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [1:0]  wb_sel,
  input  logic [20:0] wb_adr,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack,
  output logic        sdram_ready,
  output logic        ctrl_rst_n,
  input  logic        ctrl_init_done,
  output logic        ctrl_wr_req,
  output logic        ctrl_rd_req,
  input  logic        ctrl_wr_ack,
  input  logic        ctrl_rd_ack,
  output logic [21:0] ctrl_addr,
  output logic [15:0] ctrl_wdata,
  input  logic [15:0] ctrl_rdata,
  output logic        ctrl_udqm,
  output logic        ctrl_ldqm,
  output logic        timeout_err
);

  localparam int RCW = (RST_DLY < 2) ? 1 : $clog2(RST_DLY + 1);
  localparam int DCW = (RDATA_DLY < 2) ? 1 : $clog2(RDATA_DLY + 1);

  typedef enum logic [2:0] {IDLE, WREQ, RREQ, RCAP, HOLD, DRAIN} state_t;

  state_t         state;
  logic           sr_meta, sr_s;
  logic [RCW-1:0] rst_cnt;
  logic [TW-1:0]  tcnt;
  logic [DCW-1:0] dcnt;
  logic           dropped;
  logic           dropped_nx;
  logic [TW-1:0]  tcnt_nx;

  // A strobe seen low at any point before completion suppresses the bus ack.
  assign dropped_nx = dropped | ~wb_stb;
  assign tcnt_nx    = tcnt + 1'b1;

  // The synchronizer powers up asserted, so the controller stays in reset until sys_reset is seen low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_meta <= 1'b1;
      sr_s    <= 1'b1;
    end else begin
      sr_meta <= sys_reset;
      sr_s    <= sr_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt     <= '0;
      ctrl_rst_n  <= 1'b0;
      sdram_ready <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments, so every right-hand side below reads the pre-edge value.
      sdram_ready <= ctrl_rst_n & ctrl_init_done;
      if (sr_s) begin
        rst_cnt    <= '0;
        ctrl_rst_n <= 1'b0;
      end else if (rst_cnt != RCW'(RST_DLY)) begin
        rst_cnt <= rst_cnt + 1'b1;
      end else begin
        ctrl_rst_n <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ctrl_wr_req <= 1'b0;
      ctrl_rd_req <= 1'b0;
      wb_ack      <= 1'b0;
      wb_dat_o    <= '0;
      ctrl_addr   <= '0;
      ctrl_wdata  <= '0;
      ctrl_udqm   <= 1'b0;
      ctrl_ldqm   <= 1'b0;
      timeout_err <= 1'b0;
      tcnt        <= '0;
      dcnt        <= '0;
      dropped     <= 1'b0;
    end else if (sr_s) begin
      state       <= IDLE;
      ctrl_wr_req <= 1'b0;
      ctrl_rd_req <= 1'b0;
      wb_ack      <= 1'b0;
      tcnt        <= '0;
      dcnt        <= '0;
      dropped     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tcnt    <= '0;
          dcnt    <= '0;
          dropped <= 1'b0;
          if (wb_stb && !wb_ack && sdram_ready) begin
            ctrl_addr  <= {1'b0, wb_adr};
            ctrl_wdata <= wb_dat_i;
            if (wb_we) begin
              ctrl_udqm   <= ~wb_sel[1];
              ctrl_ldqm   <= ~wb_sel[0];
              ctrl_wr_req <= 1'b1;
              state       <= WREQ;
            end else begin
              ctrl_udqm   <= 1'b0;
              ctrl_ldqm   <= 1'b0;
              ctrl_rd_req <= 1'b1;
              state       <= RREQ;
            end
          end
        end
        WREQ: begin
          dropped <= dropped_nx;
          if (ctrl_wr_ack || tcnt_nx == TW'(TIMEOUT)) begin
            ctrl_wr_req <= 1'b0;
            if (!ctrl_wr_ack) timeout_err <= 1'b1;
            wb_ack <= ~dropped_nx;
            state  <= dropped_nx ? DRAIN : HOLD;
          end else begin
            tcnt <= tcnt_nx;
          end
        end
        RREQ: begin
          dropped <= dropped_nx;
          if (ctrl_rd_ack) begin
            ctrl_rd_req <= 1'b0;
            if (RDATA_DLY == 0) begin
              wb_dat_o <= ctrl_rdata;
              wb_ack   <= ~dropped_nx;
              state    <= dropped_nx ? DRAIN : HOLD;
            end else begin
              dcnt  <= DCW'(1);
              state <= RCAP;
            end
          end else if (tcnt_nx == TW'(TIMEOUT)) begin
            ctrl_rd_req <= 1'b0;
            timeout_err <= 1'b1;
            wb_dat_o    <= 16'hFFFF;
            wb_ack      <= ~dropped_nx;
            state       <= dropped_nx ? DRAIN : HOLD;
          end else begin
            tcnt <= tcnt_nx;
          end
        end
        RCAP: begin
          dropped <= dropped_nx;
          if (dcnt == DCW'(RDATA_DLY)) begin
            wb_dat_o <= ctrl_rdata;
            wb_ack   <= ~dropped_nx;
            state    <= dropped_nx ? DRAIN : HOLD;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        HOLD: begin
          if (!wb_stb) begin
            wb_ack <= 1'b0;
            state  <= IDLE;
          end
        end
        DRAIN: begin
          wb_ack <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sdram_wb_bridge.md
Name: sdram_wb_bridge

Overview:
- Sits between the kernel's Wishbone-style SDRAM port (stb/we/sel/adr/out/dat/ack) and the sdram_top request/ack controller, on the SDRAM controller clock.
- Accepts one bus transaction at a time and latches its address, data and byte lanes.
- Drives the controller's wr_req/rd_req and the DQM pins until the controller acknowledges, captures read data, and returns a clean bus ack.
- Also sequences the controller reset and flags lost transactions with a timeout.

Parameters:
RST_DLY, 3, cycles ctrl_rst_n stays low after synchronized sys_reset deasserts
RDATA_DLY, 0, cycles between the sampled ctrl_rd_ack and the capture of ctrl_rdata
TIMEOUT, 1023, maximum cycles waiting for a controller ack before abort
TW, 10, width of the timeout counter; must satisfy 2^TW > TIMEOUT

Ports:
clk  in  1  controller clock; all logic is posedge
rst_n  in  1  asynchronous active-low reset
sys_reset  in  1  kernel SDRAM reset, active-high, asynchronous to clk
wb_stb  in  1  transaction strobe
wb_we  in  1  1 = write
wb_sel  in  2  byte enables, [1] = high byte
wb_adr  in  21  word address [21:1]
wb_dat_i  in  16  write data
wb_dat_o  out  16  read data
wb_ack  out  1  transaction acknowledge
sdram_ready  out  1  controller initialized and out of reset
ctrl_rst_n  out  1  controller reset, active-low
ctrl_init_done  in  1  controller init-done flag
ctrl_wr_req  out  1  write request
ctrl_rd_req  out  1  read request
ctrl_wr_ack  in  1  write accepted/complete
ctrl_rd_ack  in  1  read complete
ctrl_addr  out  22  {1'b0, latched adr}
ctrl_wdata  out  16  latched write data
ctrl_rdata  in  16  controller read data
ctrl_udqm  out  1  high-byte mask
ctrl_ldqm  out  1  low-byte mask
timeout_err  out  1  sticky timeout flag

Behaviour:
- Reset values (rst_n=0): ctrl_rst_n=0, ctrl_wr_req=0, ctrl_rd_req=0, wb_ack=0, wb_dat_o=0, ctrl_addr=0, ctrl_wdata=0, ctrl_udqm=0, ctrl_ldqm=0, timeout_err=0, sdram_ready=0, FSM=IDLE.
- Reset sequencer:
  - sys_reset passes through a 2-flop synchronizer (sr_s).
  - While sr_s=1: counter=0, ctrl_rst_n=0.
  - After sr_s falls: counter increments each cycle; ctrl_rst_n rises in the cycle after the counter reaches RST_DLY.
  - sdram_ready = ctrl_rst_n & ctrl_init_done (registered, 1-cycle lag).
- sr_s=1 at any time: FSM forced to IDLE, requests drop to 0, wb_ack=0, timeout counter cleared. timeout_err is NOT cleared by this path; only rst_n clears it.
- FSM states: IDLE, WREQ, RREQ, RCAP, HOLD, DRAIN.
- IDLE:
  - Accepts only when wb_stb=1, wb_ack=0 and sdram_ready=1.
  - On accept, latch ctrl_addr, ctrl_wdata and DQM.
  - Write: udqm=~wb_sel[1], ldqm=~wb_sel[0]. Read: udqm=ldqm=0 (reads are always full-word).
  - Next state: WREQ if wb_we=1, else RREQ. Requests assert in the first cycle of WREQ/RREQ.
- WREQ: ctrl_wr_req held 1 until ctrl_wr_ack is sampled 1. Then req drops next cycle and the FSM goes to HOLD.
- RREQ: ctrl_rd_req held 1 until ctrl_rd_ack is sampled 1. Then req drops and the FSM goes to RCAP.
- RCAP: waits RDATA_DLY cycles, then wb_dat_o <= ctrl_rdata and the FSM goes to HOLD.
- HOLD:
  - wb_ack=1 (registered) while wb_stb=1.
  - When wb_stb is sampled 0: wb_ack=0 and the FSM returns to IDLE.
  - Minimum ack-to-next-accept gap is 1 cycle.
- Strobe dropped before completion (WREQ/RREQ/RCAP): the controller transaction still completes, then the FSM goes to DRAIN → IDLE with no wb_ack pulse.
- Timeout:
  - The counter runs in WREQ/RREQ.
  - When it reaches TIMEOUT: request drops, timeout_err=1, and for a read wb_dat_o=16'hFFFF.
  - The FSM then goes to HOLD, so the bus is acked and does not hang.
- ctrl_addr, ctrl_wdata and DQM stay stable from accept until the next accept.
- An ack that arrives with no request pending is ignored.

Test Plan:
- Reset sequence: rst_n=1, sys_reset pulse then release → ctrl_rst_n rises 2 (sync) + RST_DLY + 1 cycles after release. With ctrl_init_done=1, sdram_ready=1 one cycle later.
- Word write: adr=21'h012345, dat=16'hA5C3, sel=2'b11, controller acks 5 cycles after req → ctrl_addr=22'h012345, udqm=ldqm=0, req high exactly until the ack cycle, wb_ack high from the following cycle until stb drops.
- Byte write: sel=2'b10 → udqm=0, ldqm=1. Read with sel=2'b01 → udqm=ldqm=0. wb_dat_o=ctrl_rdata value 16'h1234 captured at the ack cycle (RDATA_DLY=0).
- Timeout: controller never acks a read, TIMEOUT=15 → req drops after 15 cycles, timeout_err=1, wb_dat_o=16'hFFFF, wb_ack asserted.
- Abort: stb drops 2 cycles into RREQ, ack arrives later → no wb_ack. The next transaction is accepted normally.
- sys_reset mid-write → ctrl_wr_req=0 within 3 cycles, FSM=IDLE, no ack. A request with sdram_ready=0 is not accepted.
